des_batch_sequencer: RTL
========================

Name: des_batch_sequencer

Overview:
- Upstream sequencer for the DES top. Latches one 64-bit key and a burst of 1..64 plaintext blocks from a valid/ready stream.
- Writes them into the key/message RAM through its write ports, then replays them back-to-back with read enables so the encrypt/decrypt datapath receives one block per cycle.
- Tracks pipeline latency and returns each block's Encrypt/Decrypt results tagged with its index.
- Sits between the host stream and the DES top's RAM ports (wr0, wr1, en, key_in, msg_in, add0, add1).

Parameters:
- AW, 6, RAM address width; maximum burst is 2**AW blocks.
- RD_LAT, 1, cycles from en/address to key/msg valid at the RAM output.
- PIPE_LAT, 1, cycles from key/msg at the encrypt input to a stable Decrypt output.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  pulse; begins a batch (honoured in IDLE only)
- num_blocks  in  AW+1  batch length, legal 1..2**AW
- cfg_key  in  64  key, sampled with start
- s_valid  in  1  plaintext beat valid
- s_ready  out  1  plaintext beat accepted when s_valid & s_ready
- s_data  in  64  plaintext block
- wr0  out  1  RAM key write strobe
- wr1  out  1  RAM message write strobe
- en  out  1  RAM read enable
- key_out  out  64  to RAM key_in
- msg_out  out  64  to RAM msg_in
- add0  out  AW  key address
- add1  out  AW  message address
- enc_in  in  64  from DES Encrypt
- dec_in  in  64  from DES Decrypt
- res_valid  out  1  result strobe, one cycle per block
- res_index  out  AW  block index of the result
- res_enc  out  64  captured ciphertext
- res_dec  out  64  captured decrypted text
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at batch end
- err  out  1  one-cycle pulse on an illegal start

Behaviour:
- Synchronous reset (rst_n=0 at a clk edge):
  - state IDLE; all outputs 0; counters and latency tracker cleared.
  - RAM contents are not touched.
  - Reset mid-batch aborts the batch: no done, no further res_valid.
- All outputs are registered.
- RAM contract: wr0 writes key_in at add0; wr1 writes msg_in at add1; en reads both banks RD_LAT cycles later.
  - wr0/wr1 are never asserted in the same cycle as en.
- FSM: IDLE -> LOAD_KEY -> LOAD_MSG -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start with num_blocks in 1..2**AW: latch N and cfg_key, go to LOAD_KEY.
  - start with num_blocks 0 or >2**AW: err=1 for one cycle, stay IDLE.
- LOAD_KEY (1 cycle): wr0=1, add0=0, key_out=latched key.
- LOAD_MSG:
  - s_ready=1.
  - A handshake at cycle t drives wr1=1, add1=wcnt, msg_out=s_data in cycle t+1; wcnt increments.
  - After the Nth handshake, s_ready drops in the same cycle the Nth beat is seen; next state RUN.
  - Gaps in s_valid stall loading indefinitely.
  - s_valid outside LOAD_MSG is ignored (s_ready=0).
- RUN (exactly N cycles): en=1, add0=0, add1=rcnt, rcnt=0..N-1.
  - Each issue pushes {valid,index} into a tracker shift register RD_LAT+PIPE_LAT deep.
- Capture:
  - When the tracker head is valid, the next cycle drives res_valid=1, res_index=index, res_enc=enc_in, res_dec=dec_in.
  - Net latency: en at cycle t -> res_valid at t+RD_LAT+PIPE_LAT+1.
  - Results emerge in index order, one per cycle, with no gaps for a gap-free RUN.
- DRAIN: wait until the tracker is empty, then go to DONE.
- DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- start while busy is ignored with no err.
- Boundaries:
  - N=1: single write, single read, single result.
  - N=2**AW: wcnt/rcnt reach 2**AW-1 with no wrap or overflow; counters are AW+1 bits.
  - A start in the same cycle as done is ignored. A start in the cycle after DONE is accepted.

Test Plan:
- Single-block golden vector: cfg_key=133457799BBCDFF1, N=1, s_data=0123456789ABCDEF, DES top attached.
  - Required: one wr0 at add0=0, one wr1 at add1=0.
  - res_valid once with res_index=0, res_enc=85E813540F0AB405, res_dec=0123456789ABCDEF, then a done pulse.
- Full burst: N=64, s_data=i (i=0..63), s_valid held high.
  - Required: 64 consecutive wr1 with add1=0..63, then 64 consecutive en.
  - res_valid contiguous for 64 cycles, res_index=0..63 in order, res_dec==i for each index.
- Stalled stream: N=4 with s_valid toggled 1,0,0,1,1,0,1.
  - Required: exactly 4 writes at add1=0..3, s_ready low after the 4th beat, RUN starts on the following cycle.
- Illegal/overlapping start: start with num_blocks=0 -> err pulse, busy stays 0.
  - start asserted during RUN of an N=8 batch -> ignored; exactly 8 results, one done.
- Reset mid-operation: assert rst_n=0 during DRAIN of an N=16 batch.
  - Required: all outputs 0 the next cycle, no done, no further res_valid.
  - A new N=2 batch afterwards completes normally.
- Latency check: en rising at cycle t.
  - Required: first res_valid at exactly t+RD_LAT+PIPE_LAT+1 (t+3 with defaults).
  - wr0/wr1 never high while en=1.

Source files
------------

// File: rtl/des_batch_sequencer.sv
// Batch sequencer in front of the DES top: loads a key and a burst of blocks into the
// key/message RAM, replays them one per cycle, and returns each block's results tagged by index.
module des_batch_sequencer #(
    parameter int AW       = 6,
    parameter int RD_LAT   = 1,
    parameter int PIPE_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   num_blocks,
    input  logic [63:0]   cfg_key,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [63:0]   s_data,
    output logic          wr0,
    output logic          wr1,
    output logic          en,
    output logic [63:0]   key_out,
    output logic [63:0]   msg_out,
    output logic [AW-1:0] add0,
    output logic [AW-1:0] add1,
    input  logic [63:0]   enc_in,
    input  logic [63:0]   dec_in,
    output logic          res_valid,
    output logic [AW-1:0] res_index,
    output logic [63:0]   res_enc,
    output logic [63:0]   res_dec,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int D = RD_LAT + PIPE_LAT;
    localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_MSG,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [AW:0]   n_q, n_d;
    logic [AW:0]   wcnt_q, wcnt_d;
    logic [AW:0]   rcnt_q, rcnt_d;
    logic          s_ready_q, s_ready_d;
    logic          wr0_q, wr0_d;
    logic          wr1_q, wr1_d;
    logic          en_q, en_d;
    logic [63:0]   key_q, key_d;
    logic [63:0]   msg_q, msg_d;
    logic [AW-1:0] add0_q, add0_d;
    logic [AW-1:0] add1_q, add1_d;
    logic          res_valid_q, res_valid_d;
    logic [AW-1:0] res_index_q, res_index_d;
    logic [63:0]   res_enc_q, res_enc_d;
    logic [63:0]   res_dec_q, res_dec_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // Tracker follows each issued read (en as seen by the RAM) until its results are stable.
    logic [D-1:0]  trk_v_q;
    logic [AW-1:0] trk_idx_q [D];

    logic          legal_n;
    logic          tracker_empty;

    assign legal_n       = (num_blocks != '0) && (num_blocks <= MAX_N);
    assign tracker_empty = !en_q && (trk_v_q == '0);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        s_ready_d   = 1'b0;
        wr0_d       = 1'b0;
        wr1_d       = 1'b0;
        en_d        = 1'b0;
        key_d       = key_q;
        msg_d       = msg_q;
        add0_d      = '0;
        add1_d      = add1_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        res_valid_d = trk_v_q[D-1];
        res_index_d = trk_v_q[D-1] ? trk_idx_q[D-1] : res_index_q;
        res_enc_d   = trk_v_q[D-1] ? enc_in : res_enc_q;
        res_dec_d   = trk_v_q[D-1] ? dec_in : res_dec_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal_n) begin
                        n_d     = num_blocks;
                        key_d   = cfg_key;
                        wr0_d   = 1'b1;
                        wcnt_d  = '0;
                        rcnt_d  = '0;
                        state_d = LOAD_KEY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_KEY: begin
                s_ready_d = 1'b1;
                state_d   = LOAD_MSG;
            end
            LOAD_MSG: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    wr1_d  = 1'b1;
                    add1_d = wcnt_q[AW-1:0];
                    msg_d  = s_data;
                    wcnt_d = wcnt_q + ONE;
                    if ((wcnt_q + ONE) == n_q) begin
                        s_ready_d = 1'b0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                en_d   = 1'b1;
                add1_d = rcnt_q[AW-1:0];
                rcnt_d = rcnt_q + ONE;
                if ((rcnt_q + ONE) == n_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tracker_empty) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            s_ready_q   <= 1'b0;
            wr0_q       <= 1'b0;
            wr1_q       <= 1'b0;
            en_q        <= 1'b0;
            key_q       <= '0;
            msg_q       <= '0;
            add0_q      <= '0;
            add1_q      <= '0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_enc_q   <= '0;
            res_dec_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            trk_v_q     <= '0;
            for (int i = 0; i < D; i++) begin
                trk_idx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            s_ready_q   <= s_ready_d;
            wr0_q       <= wr0_d;
            wr1_q       <= wr1_d;
            en_q        <= en_d;
            key_q       <= key_d;
            msg_q       <= msg_d;
            add0_q      <= add0_d;
            add1_q      <= add1_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_enc_q   <= res_enc_d;
            res_dec_q   <= res_dec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            trk_v_q[0]   <= en_q;
            trk_idx_q[0] <= add1_q;
            for (int i = 1; i < D; i++) begin
                trk_v_q[i]   <= trk_v_q[i-1];
                trk_idx_q[i] <= trk_idx_q[i-1];
            end
        end
    end

    assign s_ready   = s_ready_q;
    assign wr0       = wr0_q;
    assign wr1       = wr1_q;
    assign en        = en_q;
    assign key_out   = key_q;
    assign msg_out   = msg_q;
    assign add0      = add0_q;
    assign add1      = add1_q;
    assign res_valid = res_valid_q;
    assign res_index = res_index_q;
    assign res_enc   = res_enc_q;
    assign res_dec   = res_dec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
